// File: rtl/nv_vlib_pipe_fork2.sv
// Stream fork: one valid/ready producer broadcast to two independent consumers,
// each branch decoupled by its own 2-entry registered skid buffer.
module nv_vlib_pipe_fork2 #(
  parameter int WIDTH = 32
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             in_pvld,
  output logic             in_prdy,
  input  logic [WIDTH-1:0] in_pd,
  output logic             out0_pvld,
  input  logic             out0_prdy,
  output logic [WIDTH-1:0] out0_pd,
  output logic             out1_pvld,
  input  logic             out1_prdy,
  output logic [WIDTH-1:0] out1_pd,
  output logic             fork_idle
);

  logic [1:0]            branch_prdy;
  logic [1:0]            branch_pvld;
  logic [1:0]            branch_full;
  logic [1:0][WIDTH-1:0] branch_pd;
  logic                  accept;

  assign branch_prdy = {out1_prdy, out0_prdy};

  // Ready depends only on registered occupancy, so a consumer's ready never
  // reaches the producer combinationally.
  assign in_prdy = ~branch_full[0] & ~branch_full[1];
  assign accept  = in_pvld & in_prdy;

  for (genvar gi = 0; gi < 2; gi++) begin : g_branch
    logic [1:0]       cnt;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;
    logic             pop;

    assign pop = (cnt != 2'd0) & branch_prdy[gi];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
        cnt    <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        // NOTE: the two entries are plain flops, not a RAM, so they take the
        // reset too; outputs are then defined (zero) from the reset onward.
        entry0 <= '0;
        entry1 <= '0;
      end else begin
        if (accept) begin
          if (wr_ptr) entry1 <= in_pd;
          else        entry0 <= in_pd;
          wr_ptr <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        case ({accept, pop})
          2'b10:   cnt <= cnt + 2'd1;
          2'b01:   cnt <= cnt - 2'd1;
          default: cnt <= cnt;
        endcase
      end
    end

    assign branch_full[gi] = (cnt == 2'd2);
    assign branch_pvld[gi] = (cnt != 2'd0);
    assign branch_pd[gi]   = rd_ptr ? entry1 : entry0;
  end

  assign out0_pvld = branch_pvld[0];
  assign out0_pd   = branch_pd[0];
  assign out1_pvld = branch_pvld[1];
  assign out1_pd   = branch_pd[1];
  assign fork_idle = ~branch_pvld[0] & ~branch_pvld[1];

endmodule

// File: tb/tb_nv_vlib_pipe_fork2.sv
// Directed self-checking bench for nv_vlib_pipe_fork2: reset, streaming,
// single-branch stall, alternating ready, push/pop at one entry, mid-run reset.
module tb_nv_vlib_pipe_fork2;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_pvld;
  logic             in_prdy;
  logic [WIDTH-1:0] in_pd;
  logic             out0_pvld;
  logic             out0_prdy;
  logic [WIDTH-1:0] out0_pd;
  logic             out1_pvld;
  logic             out1_prdy;
  logic [WIDTH-1:0] out1_pd;
  logic             fork_idle;

  int checks = 0;
  int errors = 0;

  nv_vlib_pipe_fork2 #(.WIDTH(WIDTH)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .in_pvld        (in_pvld),
    .in_prdy        (in_prdy),
    .in_pd          (in_pd),
    .out0_pvld      (out0_pvld),
    .out0_prdy      (out0_prdy),
    .out0_pd        (out0_pd),
    .out1_pvld      (out1_pvld),
    .out1_prdy      (out1_prdy),
    .out1_pd        (out1_pd),
    .fork_idle      (fork_idle)
  );

  always #5 clk = ~clk;

  // One clock: outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_pvld = 1'b0; in_pd = '0; out0_prdy = 1'b1; out1_prdy = 1'b1;
    #1;
    repeat (3) tick();
    checks++; if (in_prdy !== 1'b1)    begin errors++; $display("FAIL rst_in_prdy got %0b exp 1", in_prdy); end
    checks++; if (out0_pvld !== 1'b0)  begin errors++; $display("FAIL rst_out0_pvld got %0b exp 0", out0_pvld); end
    checks++; if (out1_pvld !== 1'b0)  begin errors++; $display("FAIL rst_out1_pvld got %0b exp 0", out1_pvld); end
    checks++; if (out0_pd !== 32'h0)   begin errors++; $display("FAIL rst_out0_pd got %h exp 0", out0_pd); end
    checks++; if (out1_pd !== 32'h0)   begin errors++; $display("FAIL rst_out1_pd got %h exp 0", out1_pd); end
    checks++; if (fork_idle !== 1'b1)  begin errors++; $display("FAIL rst_idle got %0b exp 1", fork_idle); end
    rst = 1'b0;
    tick();
    checks++; if (in_prdy !== 1'b1 || fork_idle !== 1'b1 || out0_pvld !== 1'b0 || out1_pvld !== 1'b0)
      begin errors++; $display("FAIL post_rst_idle got prdy=%0b idle=%0b v0=%0b v1=%0b exp 1 1 0 0",
                               in_prdy, fork_idle, out0_pvld, out1_pvld); end
  endtask

  task automatic test_streaming();
    out0_prdy = 1'b1; out1_prdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_pvld = 1'b1; in_pd = 32'h10 + 32'(i);
      checks++; if (in_prdy !== 1'b1) begin errors++; $display("FAIL stream_in_prdy beat %0d got %0b exp 1", i, in_prdy); end
      tick();
      checks++; if (out0_pvld !== 1'b1 || out0_pd !== 32'h10 + 32'(i))
        begin errors++; $display("FAIL stream_out0 beat %0d got v=%0b pd=%h exp v=1 pd=%h", i, out0_pvld, out0_pd, 32'h10 + 32'(i)); end
      checks++; if (out1_pvld !== 1'b1 || out1_pd !== 32'h10 + 32'(i))
        begin errors++; $display("FAIL stream_out1 beat %0d got v=%0b pd=%h exp v=1 pd=%h", i, out1_pvld, out1_pd, 32'h10 + 32'(i)); end
    end
    in_pvld = 1'b0;
    tick();
    checks++; if (fork_idle !== 1'b1) begin errors++; $display("FAIL stream_drain_idle got %0b exp 1", fork_idle); end
  endtask

  task automatic test_stall();
    out0_prdy = 1'b1; out1_prdy = 1'b0;
    in_pvld = 1'b1; in_pd = 32'hA0;
    checks++; if (in_prdy !== 1'b1) begin errors++; $display("FAIL stall_accept_a0 got %0b exp 1", in_prdy); end
    tick();
    in_pd = 32'hA1;
    checks++; if (in_prdy !== 1'b1) begin errors++; $display("FAIL stall_accept_a1 got %0b exp 1", in_prdy); end
    checks++; if (out0_pd !== 32'hA0 || out1_pd !== 32'hA0)
      begin errors++; $display("FAIL stall_head_a0 got %h/%h exp a0/a0", out0_pd, out1_pd); end
    tick();
    in_pd = 32'hA2;
    checks++; if (in_prdy !== 1'b0) begin errors++; $display("FAIL stall_full_prdy got %0b exp 0", in_prdy); end
    checks++; if (out0_pvld !== 1'b1 || out0_pd !== 32'hA1)
      begin errors++; $display("FAIL stall_out0_a1 got v=%0b pd=%h exp v=1 pd=a1", out0_pvld, out0_pd); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (in_prdy !== 1'b0) begin errors++; $display("FAIL stall_hold_prdy cyc %0d got %0b exp 0", i, in_prdy); end
      checks++; if (out0_pvld !== 1'b0) begin errors++; $display("FAIL stall_out0_drained cyc %0d got %0b exp 0", i, out0_pvld); end
      checks++; if (out1_pvld !== 1'b1 || out1_pd !== 32'hA0)
        begin errors++; $display("FAIL stall_out1_hold cyc %0d got v=%0b pd=%h exp v=1 pd=a0", i, out1_pvld, out1_pd); end
    end
    out1_prdy = 1'b1;
    tick();
    checks++; if (in_prdy !== 1'b1) begin errors++; $display("FAIL release_prdy got %0b exp 1", in_prdy); end
    checks++; if (out1_pd !== 32'hA1 || out0_pvld !== 1'b0)
      begin errors++; $display("FAIL release_out1_a1 got pd1=%h v0=%0b exp a1 0", out1_pd, out0_pvld); end
    tick();
    in_pvld = 1'b0;
    checks++; if (out0_pvld !== 1'b1 || out0_pd !== 32'hA2 || out1_pvld !== 1'b1 || out1_pd !== 32'hA2)
      begin errors++; $display("FAIL release_a2 got %0b:%h %0b:%h exp 1:a2 1:a2", out0_pvld, out0_pd, out1_pvld, out1_pd); end
    tick();
    checks++; if (fork_idle !== 1'b1) begin errors++; $display("FAIL stall_final_idle got %0b exp 1", fork_idle); end
  endtask

  task automatic test_alternate();
    int next_in = 0;
    int exp0 = 0;
    int exp1 = 0;
    bit acc;
    for (int c = 0; c < 200 && (exp0 < 16 || exp1 < 16); c++) begin
      out0_prdy = (c % 2 == 0); out1_prdy = (c % 2 == 1);
      in_pvld = (next_in < 16); in_pd = 32'(next_in);
      if (out0_pvld && out0_prdy) begin
        checks++; if (out0_pd !== 32'(exp0)) begin errors++; $display("FAIL alt_out0 got %h exp %h", out0_pd, 32'(exp0)); end
        exp0++;
      end
      if (out1_pvld && out1_prdy) begin
        checks++; if (out1_pd !== 32'(exp1)) begin errors++; $display("FAIL alt_out1 got %h exp %h", out1_pd, 32'(exp1)); end
        exp1++;
      end
      acc = in_pvld && in_prdy;
      tick();
      if (acc) next_in++;
    end
    in_pvld = 1'b0;
    checks++; if (exp0 != 16 || exp1 != 16) begin errors++; $display("FAIL alt_count got %0d/%0d exp 16/16", exp0, exp1); end
    checks++; if (fork_idle !== 1'b1) begin errors++; $display("FAIL alt_no_extra got idle=%0b exp 1", fork_idle); end
  endtask

  task automatic test_pushpop_cnt1();
    out0_prdy = 1'b0; out1_prdy = 1'b0;
    in_pvld = 1'b1; in_pd = 32'h55;
    tick();
    checks++; if (out0_pd !== 32'h55 || out1_pd !== 32'h55 || in_prdy !== 1'b1)
      begin errors++; $display("FAIL pp_load got %h/%h prdy=%0b exp 55/55 1", out0_pd, out1_pd, in_prdy); end
    out0_prdy = 1'b1; out1_prdy = 1'b1; in_pd = 32'h66;
    tick();
    in_pvld = 1'b0;
    checks++; if (out0_pvld !== 1'b1 || out0_pd !== 32'h66 || out1_pvld !== 1'b1 || out1_pd !== 32'h66)
      begin errors++; $display("FAIL pp_new_head got %0b:%h %0b:%h exp 1:66 1:66", out0_pvld, out0_pd, out1_pvld, out1_pd); end
    tick();
    checks++; if (fork_idle !== 1'b1) begin errors++; $display("FAIL pp_cnt_one got idle=%0b exp 1", fork_idle); end
  endtask

  task automatic test_reset_mid();
    out0_prdy = 1'b1; out1_prdy = 1'b0;
    in_pvld = 1'b1; in_pd = 32'hB0;
    tick();
    in_pd = 32'hB1;
    tick();
    in_pvld = 1'b0;
    checks++; if (out1_pvld !== 1'b1 || in_prdy !== 1'b0)
      begin errors++; $display("FAIL mid_setup got v1=%0b prdy=%0b exp 1 0", out1_pvld, in_prdy); end
    #3 rst = 1'b1;
    #1;
    checks++; if (out1_pvld !== 1'b0 || out1_pd !== 32'h0)
      begin errors++; $display("FAIL mid_async_clear got v1=%0b pd1=%h exp 0 0", out1_pvld, out1_pd); end
    checks++; if (fork_idle !== 1'b1 || in_prdy !== 1'b1)
      begin errors++; $display("FAIL mid_async_idle got idle=%0b prdy=%0b exp 1 1", fork_idle, in_prdy); end
    tick();
    rst = 1'b0; out1_prdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out0_pvld !== 1'b0 || out1_pvld !== 1'b0 || fork_idle !== 1'b1 || in_prdy !== 1'b1)
        begin errors++; $display("FAIL mid_after cyc %0d got v0=%0b v1=%0b idle=%0b prdy=%0b exp 0 0 1 1",
                                 i, out0_pvld, out1_pvld, fork_idle, in_prdy); end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_alternate();
    test_pushpop_cnt1();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nv_vlib_pipe_fork2.md
Name: nv_vlib_pipe_fork2

Overview:
- Stream fork: one valid/ready producer stream is broadcast to two independent valid/ready consumers. This is the split counterpart of the AND-style join used to combine two valids.
- Each branch has its own 2-entry registered skid buffer, so a stalled consumer never blocks the other until its own buffer fills.
- Used between NVDLA pipeline stages wherever one payload feeds two downstream units, e.g. a shared read response feeding two datapaths.

Parameters:
- WIDTH, 32, payload width in bits of in_pd/out0_pd/out1_pd.

Ports:
- nvdla_core_clk  input  1  single clock; all state on rising edge.
- nvdla_core_rst  input  1  asynchronous, active-high reset.
- in_pvld  input  1  producer valid.
- in_prdy  output  1  producer ready.
- in_pd  input  WIDTH  producer payload.
- out0_pvld  output  1  branch 0 valid.
- out0_prdy  input  1  branch 0 ready.
- out0_pd  output  WIDTH  branch 0 payload.
- out1_pvld  output  1  branch 1 valid.
- out1_prdy  input  1  branch 1 ready.
- out1_pd  output  WIDTH  branch 1 payload.
- fork_idle  output  1  both branch buffers empty.

Behaviour:
- Reset (async assert, sync use after deassert):
  - Both branch counts = 0, both head/tail pointers = 0, all entry registers = 0.
  - out0_pvld = out1_pvld = 0, out0_pd = out1_pd = 0, fork_idle = 1.
  - in_prdy = 1 during and after reset.
  - Reset mid-operation discards all buffered data immediately; nothing already in a buffer is presented after reset.
- Per-branch state:
  - cnt ∈ {0,1,2}, wr_ptr and rd_ptr (1 bit each, wrap 1→0), two WIDTH-bit entries.
  - full_n = (cnt == 2).
- Input handshake:
  - in_prdy = !full_0 & !full_1, decoded only from registered state. There is no combinational path from out*_prdy to in_prdy.
  - Accept = in_pvld & in_prdy. On accept, in_pd is written at wr_ptr of BOTH branches, both wr_ptr toggle, and both cnt increment (subject to same-cycle pop).
  - A beat is always pushed to both branches in the same cycle; partial pushes never occur.
- Output handshake (each branch independent):
  - outN_pvld = (cnt_N != 0).
  - outN_pd = entry[rd_ptr_N], a registered value with no combinational path from in_pd.
  - Pop = outN_pvld & outN_prdy: rd_ptr toggles, cnt decrements.
  - outN_pd and outN_pvld hold steady while outN_pvld & !outN_prdy.
- Simultaneous push and pop on a branch:
  - cnt unchanged; write and read target different entries.
  - This is legal at cnt = 1. At cnt = 0 a pop is impossible; at cnt = 2 a push is impossible.
- Latency and throughput:
  - 1 cycle from accept to outN_pvld.
  - Full rate (1 beat/cycle) when both consumers hold ready = 1; each cnt settles at 1.
- Backpressure:
  - A branch stalled with cnt = 2 forces in_prdy = 0. The other branch drains its buffered beats and then idles.
  - in_prdy rises the cycle after the stalled branch pops.
- Ordering: each branch delivers beats in acceptance order with no loss or duplication.
- fork_idle = (cnt_0 == 0) & (cnt_1 == 0), registered-state decode.
- No X on outputs while in reset or after reset; payload registers reset to 0.

Test Plan:
- Reset then idle: assert nvdla_core_rst for 3 cycles, in_pvld = 0 → out0_pvld = out1_pvld = 0, out*_pd = 0, in_prdy = 1, fork_idle = 1.
- Streaming:
  - Stimulus: both out*_prdy = 1, in_pvld = 1 for 8 cycles with pd = 0x10..0x17.
  - Response: each branch presents 0x10..0x17 on consecutive cycles starting 1 cycle after the first accept; in_prdy stays 1 throughout.
- Single-branch stall:
  - Stimulus: out1_prdy = 0, out0_prdy = 1, send 0xA0, 0xA1, 0xA2.
  - Response: 0xA0 and 0xA1 accepted; in_prdy = 0 while 0xA2 is held; branch 0 emits 0xA0, 0xA1, then out0_pvld = 0; out1_pd holds 0xA0 with out1_pvld = 1.
  - Release: raise out1_prdy → in_prdy returns to 1 the next cycle; 0xA2 reaches both branches in order.
- Alternating ready:
  - Stimulus: out0_prdy toggles 1,0,1,0 and out1_prdy toggles 0,1,0,1 over a 16-beat ramp 0x00..0x0F.
  - Response: both branches deliver 0x00..0x0F exactly once, in order, with no drops or duplicates.
- Simultaneous push/pop at cnt = 1: with one beat buffered per branch, accept a new beat while both pop → cnt stays 1, next out*_pd equals the new beat.
- Reset mid-operation:
  - Stimulus: with 2 beats buffered in branch 1, assert reset asynchronously between clock edges.
  - Response: out1_pvld = 0 immediately without waiting for a clock edge; after release fork_idle = 1, in_prdy = 1, and old data never appears.
